// File: rtl/spi_peripheral_command_parser.sv
// spi_peripheral_command_parser: SPI mode-0 peripheral that decodes a 16-bit header
// and turns the frame into burst write/read strobes on the system clock.
module spi_peripheral_command_parser #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int LEN_WIDTH     = 5,
    parameter int READ_LATENCY  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic [ADDRESS_WIDTH-1:0] spi_write_address,
    output logic                     spi_write_address_valid,
    output logic [DATA_WIDTH-1:0]    spi_write_data,
    output logic                     spi_write_strobe,
    output logic [LEN_WIDTH-1:0]     spi_write_burst_length,
    output logic [ADDRESS_WIDTH-1:0] spi_read_address,
    output logic                     spi_read_address_valid,
    input  logic [DATA_WIDTH-1:0]    spi_read_data,
    output logic                     spi_read_strobe,
    output logic [LEN_WIDTH-1:0]     spi_read_burst_length,
    output logic                     busy,
    output logic [7:0]               error_count
);
    localparam int CNT_W = $clog2(DATA_WIDTH > 16 ? DATA_WIDTH : 16);
    localparam int CW    = LEN_WIDTH + 1;
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(15);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, HEADER, WRITE_DATA, TURNAROUND, READ_DATA, DRAIN} state_t;
    state_t r_state, w_next;

    logic [1:0]              r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                    r_sclk_d, r_cs_d;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-2:0]   r_shift;
    logic [CW-1:0]           r_word_cnt;
    logic [DATA_WIDTH-1:0]   r_prefetch, r_miso_sh;
    logic [READ_LATENCY-1:0] r_pipe;
    logic                    r_miso;

    logic                     w_mosi, w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic                     w_bit_last, w_tick, w_abort, w_err;
    logic                     w_hdr_done, w_wr_word, w_rd_load, w_rd_word;
    logic                     w_hdr_wr;
    logic [LEN_WIDTH-1:0]     w_hdr_len;
    logic [ADDRESS_WIDTH-1:0] w_hdr_addr;
    logic [CW-1:0]            w_len;

    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
    // Header bit 0 is still on mosi when the 16th rising edge is seen
    assign w_hdr_wr    = r_shift[14];
    assign w_hdr_len   = r_shift[13 -: LEN_WIDTH];
    assign w_hdr_addr  = {r_shift[ADDRESS_WIDTH-2:0], w_mosi};
    assign miso        = r_miso & ~r_cs_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_cs_sync   <= {r_cs_sync[0], cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state != IDLE && w_cs_rise) w_next = IDLE;
        else if (r_state == IDLE && w_cs_fall) w_next = HEADER;
        else if (w_hdr_done) w_next = w_hdr_len == '0 ? DRAIN : (w_hdr_wr ? WRITE_DATA : TURNAROUND);
        else if (w_rd_load && r_state == TURNAROUND) w_next = READ_DATA;
    end

    always_comb begin
        busy       = r_state != IDLE;
        w_len      = {1'b0, r_state == WRITE_DATA ? spi_write_burst_length : spi_read_burst_length};
        w_bit_last = (r_state == HEADER && r_bit_cnt == HDR_LAST)
                  || (r_state == TURNAROUND && r_bit_cnt == DUMMY_LAST)
                  || ((r_state == WRITE_DATA || r_state == READ_DATA) && r_bit_cnt == WORD_LAST);
        w_tick     = w_sclk_rise && !w_cs_rise && w_bit_last;
        w_hdr_done = w_tick && r_state == HEADER;
        w_wr_word  = w_tick && r_state == WRITE_DATA;
        w_rd_load  = w_tick && (r_state == TURNAROUND || r_state == READ_DATA);
        w_rd_word  = w_tick && r_state == READ_DATA;
        w_abort    = w_cs_rise && r_bit_cnt != '0 && r_state != IDLE && r_state != DRAIN;
        w_err      = (w_hdr_done && w_hdr_len == '0) || (w_wr_word && r_word_cnt >= w_len)
                  || (w_rd_word && r_word_cnt > w_len) || w_abort;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spi_write_address       <= '0;
            spi_write_address_valid <= 1'b0;
            spi_write_data          <= '0;
            spi_write_strobe        <= 1'b0;
            spi_write_burst_length  <= LEN_WIDTH'(1);
            spi_read_address        <= '0;
            spi_read_address_valid  <= 1'b0;
            spi_read_strobe         <= 1'b0;
            spi_read_burst_length   <= LEN_WIDTH'(1);
            error_count             <= 8'd0;
            r_bit_cnt               <= '0;
            r_shift                 <= '0;
            r_word_cnt              <= '0;
            r_prefetch              <= '0;
            r_miso_sh               <= '0;
            r_pipe                  <= '0;
            r_miso                  <= 1'b0;
        end else begin
            spi_write_strobe        <= 1'b0;
            spi_write_address_valid <= 1'b0;
            spi_read_strobe         <= 1'b0;
            spi_read_address_valid  <= 1'b0;
            r_pipe <= (r_pipe << 1) | READ_LATENCY'(spi_read_strobe);
            if (r_pipe[READ_LATENCY-1]) r_prefetch <= spi_read_data;
            if (w_err && error_count != 8'hFF) error_count <= error_count + 8'd1;
            if (r_state == IDLE) begin
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_word_cnt <= '0;
                r_miso_sh  <= '0;
                r_miso     <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_shift   <= {r_shift[DATA_WIDTH-3:0], w_mosi};
                    r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + CNT_W'(1);
                end
                if (w_sclk_fall) begin
                    r_miso    <= r_miso_sh[DATA_WIDTH-1];
                    r_miso_sh <= {r_miso_sh[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (w_hdr_done && w_hdr_wr) begin
                spi_write_address      <= w_hdr_addr;
                spi_write_burst_length <= w_hdr_len;
            end
            if (w_hdr_done && !w_hdr_wr) begin
                spi_read_address       <= w_hdr_addr;
                spi_read_burst_length  <= w_hdr_len;
                spi_read_strobe        <= w_hdr_len != '0;
                spi_read_address_valid <= w_hdr_len != '0;
            end
            // Word counters stop one past the length so the compares never wrap
            if ((w_wr_word || w_rd_load) && r_word_cnt <= w_len) r_word_cnt <= r_word_cnt + CW'(1);
            if (w_wr_word && r_word_cnt < w_len) begin
                spi_write_strobe        <= 1'b1;
                spi_write_address_valid <= r_word_cnt == '0;
                spi_write_data          <= {r_shift, w_mosi};
            end
            if (w_rd_load) begin
                r_miso_sh       <= r_word_cnt < w_len ? r_prefetch : '0;
                spi_read_strobe <= r_word_cnt + CW'(1) < w_len;
            end
        end
    end
endmodule

// File: tb/tb_spi_peripheral_command_parser.sv
// tb_spi_peripheral_command_parser: drives SPI frames as a mode-0 master and checks the
// strobes, read-back words and error counter against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_peripheral_command_parser;
    logic        clock = 0, reset = 1, sclk = 0, cs_n = 1, mosi = 0;
    logic        miso;
    logic [3:0]  spi_write_address, spi_read_address;
    logic        spi_write_address_valid, spi_write_strobe;
    logic        spi_read_address_valid, spi_read_strobe;
    logic [31:0] spi_write_data;
    logic [31:0] spi_read_data = 0;
    logic [4:0]  spi_write_burst_length, spi_read_burst_length;
    logic        busy;
    logic [7:0]  error_count;

    int tests = 0, fails = 0;

    spi_peripheral_command_parser dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .spi_write_address(spi_write_address), .spi_write_address_valid(spi_write_address_valid),
        .spi_write_data(spi_write_data), .spi_write_strobe(spi_write_strobe),
        .spi_write_burst_length(spi_write_burst_length),
        .spi_read_address(spi_read_address), .spi_read_address_valid(spi_read_address_valid),
        .spi_read_data(spi_read_data), .spi_read_strobe(spi_read_strobe),
        .spi_read_burst_length(spi_read_burst_length),
        .busy(busy), .error_count(error_count)
    );

    always #5 clock = ~clock;

    // Downstream memory: writes land in mem, reads answer exactly 8 clocks after each strobe
    logic [31:0] mem [16] = '{default: 32'd0};
    logic [41:0] wq[$];
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          ncyc = 0, rd_cnt = 0, rd_vcnt = 0;
    logic [8:0]  rd_first = 0;
    logic [3:0]  wptr = 0, rptr = 0;

    always @(negedge clock) begin
        ncyc++;
        if (due_q.size() > 0 && due_q[0] == ncyc) begin
            spi_read_data = dat_q.pop_front();
            void'(due_q.pop_front());
        end else spi_read_data = $urandom;
        if (spi_write_strobe) begin
            wq.push_back({spi_write_address_valid, spi_write_burst_length, spi_write_address, spi_write_data});
            if (spi_write_address_valid) wptr = spi_write_address;
            mem[wptr] = spi_write_data;
            wptr++;
        end
        if (spi_read_strobe) begin
            rd_cnt++;
            if (spi_read_address_valid) begin
                rd_vcnt++;
                rptr = spi_read_address;
                rd_first = {spi_read_address, spi_read_burst_length};
            end
            due_q.push_back(ncyc + 8);
            dat_q.push_back(mem[rptr]);
            rptr++;
        end
    end

    logic [31:0] ref_mem [16] = '{default: 32'd0};
    logic [31:0] tx [8];
    logic [31:0] rx_words [8];
    int          exp_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input int n, input logic [63:0] out, output logic [63:0] in);
        in = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = out[i];
            #80 sclk = 1;
            in = {in[62:0], miso};
            #80 sclk = 0;
        end
    endtask

    task automatic check_reset();
        chk("rst_miso", miso, 0);
        chk("rst_wstb", spi_write_strobe, 0);
        chk("rst_wav", spi_write_address_valid, 0);
        chk("rst_wdata", spi_write_data, 0);
        chk("rst_waddr", spi_write_address, 0);
        chk("rst_wlen", spi_write_burst_length, 1);
        chk("rst_rstb", spi_read_strobe, 0);
        chk("rst_rav", spi_read_address_valid, 0);
        chk("rst_raddr", spi_read_address, 0);
        chk("rst_rlen", spi_read_burst_length, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", error_count, 0);
    endtask

    // One frame: header, dummy byte for reads, nw full words, then extra stray bits
    task automatic run_frame(input logic wr, input logic [4:0] len, input logic [3:0] addr,
                             input int nw, input int extra);
        logic [63:0] rx;
        logic [15:0] hdr;
        logic [3:0]  a;
        int wbase, rbase, rvbase, k, xr;
        wbase = wq.size();
        rbase = rd_cnt;
        rvbase = rd_vcnt;
        hdr = {wr, len, 6'($urandom), addr};
        cs_n = 0;
        #200;
        spi_bits(16, {48'd0, hdr}, rx);
        if (!wr) spi_bits(8, 64'd0, rx);
        for (int i = 0; i < nw; i++) begin
            spi_bits(32, {32'd0, tx[i]}, rx);
            rx_words[i] = rx[31:0];
        end
        if (extra > 0) spi_bits(extra, {$urandom, $urandom}, rx);
        #100 cs_n = 1;
        #600;
        if (wr) begin
            k = nw < int'(len) ? nw : int'(len);
            chk("wr_count", wq.size() - wbase, k);
            for (int i = 0; i < k; i++) begin
                a = addr + 4'(i);
                ref_mem[a] = tx[i];
                if (wbase + i < wq.size()) chk("wr_word", wq[wbase + i], {1'(i == 0), len, addr, tx[i]});
            end
            exp_err += (nw > int'(len) ? nw - int'(len) : 0) + (extra > 0 ? 1 : 0);
        end else begin
            xr = nw + 2 < int'(len) ? nw + 2 : int'(len);
            chk("rd_count", rd_cnt - rbase, xr);
            chk("rd_first_valid", rd_vcnt - rvbase, 1);
            chk("rd_addr_len", rd_first, {addr, len});
            for (int i = 0; i < nw; i++) begin
                a = addr + 4'(i);
                chk("rd_word", rx_words[i], i < int'(len) ? ref_mem[a] : 32'd0);
            end
            exp_err += nw > int'(len) ? nw - int'(len) : 0;
        end
        chk("err", error_count, exp_err);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        logic [63:0] rx;
        repeat (4) @(posedge clock);
        #1 reset = 0;
        @(posedge clock);
        #1 check_reset();

        tx[0] = 32'h12345678;
        run_frame(1, 5'd1, 4'h0, 1, 0);
        chk("req027_data", mem[0], 32'h12345678);

        tx[0] = 32'h55550000;
        tx[1] = 32'h44BB44BB;
        run_frame(1, 5'd2, 4'hC, 2, 0);
        chk("req028_err", error_count, 0);

        run_frame(0, 5'd2, 4'hC, 2, 0);
        chk("req029_w0", rx_words[0], 32'h55550000);
        chk("req029_w1", rx_words[1], 32'h44BB44BB);

        run_frame(0, 5'd1, 4'hC, 2, 0);
        chk("req030_w1", rx_words[1], 0);
        chk("req030_err", error_count, 1);

        tx[0] = $urandom;
        run_frame(1, 5'd1, 4'h5, 0, 10);
        chk("req031_err", error_count, 2);

        for (int it = 0; it < 10; it++) begin
            logic wr;
            logic [4:0] len;
            int nw;
            wr = 1'($urandom_range(0, 1));
            len = 5'($urandom_range(1, 3));
            nw = int'(len) + $urandom_range(0, 1);
            for (int i = 0; i < 8; i++) tx[i] = $urandom;
            run_frame(wr, len, 4'($urandom), nw, (wr && $urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 0);
        end

        cs_n = 0;
        #200;
        spi_bits(16, 64'h8003, rx);
        #400;
        exp_err++;
        chk("req032_err", error_count, exp_err);
        chk("req032_busy", busy, 1);
        @(posedge clock);
        #1 reset = 1;
        repeat (3) @(posedge clock);
        #1 check_reset();
        reset = 0;
        #200 cs_n = 1;
        #600;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_err", error_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_peripheral_command_parser.md
SPI_PERIPHERAL_COMMAND_PARSER -- requirements
Module: spi_peripheral_command_parser

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 5, burst length width.
REQ-004 SHALL have parameter READ_LATENCY, default 8, clocks from spi_read_strobe to spi_read_data capture.
REQ-005 SHALL have ports, clock and reset first:
- clock  in  1  system clock; reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous, active-high.
- sclk  in  1  SPI clock, mode 0, asynchronous.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- spi_write_address  out  ADDRESS_WIDTH  burst start address.
- spi_write_address_valid  out  1  high with first write strobe of a burst only.
- spi_write_data  out  DATA_WIDTH  received word.
- spi_write_strobe  out  1  one-clock pulse per received word.
- spi_write_burst_length  out  LEN_WIDTH  header length field.
- spi_read_address  out  ADDRESS_WIDTH  burst start address.
- spi_read_address_valid  out  1  high with first read strobe of a burst only.
- spi_read_data  in  DATA_WIDTH  word returned downstream.
- spi_read_strobe  out  1  one-clock pulse per requested word.
- spi_read_burst_length  out  LEN_WIDTH  header length field.
- busy  out  1  high whenever state is not IDLE.
- error_count  out  8  saturating frame error counter.

Function
REQ-006 SHALL pass sclk, cs_n, mosi through 2-flop synchronizers and detect sclk edges from the synchronized copy; clock SHALL be at least 4x sclk.
REQ-007 SHALL sample mosi on each detected rising sclk edge and update miso after each detected falling edge.
REQ-008 SHALL decode a 16-bit header: bit 15 = 1 write / 0 read; bits [14:14-LEN_WIDTH+1] = length; bits [ADDRESS_WIDTH-1:0] = address; other bits ignored.
REQ-009 SHALL use states IDLE, HEADER, WRITE_DATA, TURNAROUND, READ_DATA, DRAIN.
REQ-010 SHALL move IDLE->HEADER when synchronized cs_n falls, with the bit counter cleared.
REQ-011 SHALL, on header completion, load the address and length outputs and go to WRITE_DATA (write) or TURNAROUND (read).
REQ-012 SHALL treat a header with length 0 as an error: increment error_count, issue no strobes, go to DRAIN.
REQ-013 SHALL, in WRITE_DATA, pulse spi_write_strobe for one clock per completed DATA_WIDTH-bit word, with spi_write_data valid in the same cycle.
REQ-014 SHALL raise spi_write_address_valid only with the first strobe of each burst.
REQ-015 SHALL, on entering TURNAROUND, pulse spi_read_strobe with spi_read_address_valid=1 and then consume 8 dummy sclk bits.
REQ-016 SHALL capture spi_read_data exactly READ_LATENCY clocks after each spi_read_strobe into a prefetch register.
REQ-017 SHALL load the prefetch register into the miso shifter at each word boundary in READ_DATA.
REQ-018 SHALL issue the next read strobe (address_valid=0) at the same boundary while words issued < length.
REQ-019 SHALL shift zeros on miso for words beyond the length and increment error_count once per such word.
REQ-020 SHALL increment error_count if the write word count exceeds the length.
REQ-021 SHALL, when cs_n rises mid-word or mid-header, discard the partial bits, issue no strobe, increment error_count, and return to IDLE.
REQ-022 SHALL return to IDLE when cs_n rises on a word boundary with no error.
REQ-023 SHALL hold DRAIN until cs_n rises, then go to IDLE.
REQ-024 SHALL drive miso=0 while cs_n is high.
REQ-025 SHALL saturate error_count at 255.

Reset
REQ-026 SHALL, on reset, set all strobes, address_valid, miso, busy and data/address outputs to 0, both burst_length outputs to 1, error_count to 0, and state to IDLE, overriding any frame in progress.

Verification
REQ-027 Write header 0x8400 (len 1, addr 0) + 0x12345678 -> one write strobe, address_valid=1, data 0x12345678, burst_length 1.
REQ-028 Write len 2, addr 0xC, words 0x55550000/0x44BB44BB -> two strobes; address_valid only on the first; error_count 0.
REQ-029 Read len 2, addr 0xC, spi_read_data model with 8-clock latency -> two read strobes, miso returns 0x55550000 then 0x44BB44BB.
REQ-030 Read len 1 clocked for two words -> second word all zeros, error_count=1.
REQ-031 cs_n raised after 10 data bits of a write -> no strobe, error_count +1, busy=0.
REQ-032 Header with length 0, then reset asserted mid-frame -> error_count +1, then all outputs at reset values.
